// File: rtl/lcd_rgb_rx.sv
// RGB565 LCD bus receiver: recovers pixel coordinates, frame/line markers and active geometry.
// Define LCD_RX_MEAS_EN for measured resolution, geometry consistency checking, lock and frame_err.
module lcd_rgb_rx #(
    parameter bit SYNC_POL = 1'b0,
    parameter int H_DISP   = 480,
    parameter int V_DISP   = 272
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_de,
    input  logic [15:0] lcd_rgb,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        line_end,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic        rx_locked,
    output logic        frame_err
);
    localparam logic [10:0] XY_MAX = 11'd2047;

    typedef enum logic [1:0] {IDLE, VBLANK, LINE, HBLANK} state_t;

    state_t      state_q;
    state_t      eff_state;
    logic        vs_act_q, vs_act_prev_q, de_s1_q, de_prev_q;
    logic [15:0] rgb_s1_q;
    logic [10:0] x_q, y_q, x_inc;
    logic [15:0] data_q;
    logic        valid_q, fs_q, le_q;
    logic [10:0] xpos_q, ypos_q;
    logic [10:0] h_q, v_q;
    logic        locked_q;
    logic        vs_edge, de_rise;
    logic        unused_hs;

    // Line timing comes from DE alone; HS is accepted but carries no extra information.
    assign unused_hs = lcd_hs;

    assign vs_edge   = vs_act_q & ~vs_act_prev_q;
    assign de_rise   = de_s1_q & ~de_prev_q;
    // A VS edge closes the frame first, so the DE logic sees VBLANK on that same cycle.
    assign eff_state = vs_edge ? VBLANK : state_q;
    assign x_inc     = (x_q == XY_MAX) ? XY_MAX : x_q + 11'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q      <= 1'b0;
            vs_act_prev_q <= 1'b0;
            de_s1_q       <= 1'b0;
            de_prev_q     <= 1'b0;
            rgb_s1_q      <= '0;
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            fs_q          <= 1'b0;
            le_q          <= 1'b0;
        end else begin
            vs_act_q      <= (lcd_vs == SYNC_POL);
            vs_act_prev_q <= vs_act_q;
            de_s1_q       <= lcd_de;
            de_prev_q     <= de_s1_q;
            rgb_s1_q      <= lcd_rgb;
            data_q        <= rgb_s1_q;
            valid_q       <= 1'b0;
            fs_q          <= 1'b0;
            le_q          <= 1'b0;
            if (vs_edge) begin
                state_q <= VBLANK;
                x_q     <= '0;
                y_q     <= '0;
            end
            // line_end looks one sample ahead at the raw DE so it lands on the last pixel.
            case (eff_state)
                VBLANK, HBLANK: begin
                    if (de_rise) begin
                        state_q <= LINE;
                        x_q     <= '0;
                        valid_q <= 1'b1;
                        xpos_q  <= '0;
                        ypos_q  <= (eff_state == VBLANK) ? 11'd0 : y_q;
                        fs_q    <= (eff_state == VBLANK);
                        le_q    <= ~lcd_de;
                    end
                end
                LINE: begin
                    if (de_s1_q) begin
                        x_q     <= x_inc;
                        valid_q <= 1'b1;
                        xpos_q  <= x_inc;
                        ypos_q  <= y_q;
                        le_q    <= ~lcd_de;
                    end else begin
                        state_q <= HBLANK;
                        y_q     <= (y_q == XY_MAX) ? XY_MAX : y_q + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_RX_MEAS_EN
    logic [11:0] line_len, first_len_q;
    logic        line_done, x_sat, frame_good;
    logic        bad_q, have_prev_q, err_q;

    assign line_done  = (eff_state == LINE) && !de_s1_q;
    assign x_sat      = (eff_state == LINE) && de_s1_q && (x_q == XY_MAX);
    assign line_len   = {1'b0, x_q} + 12'd1;
    assign frame_good = !bad_q && (y_q != 11'd0) && (state_q != LINE) && !first_len_q[11];

    // h_q/v_q double as the dimensions of the previous good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_len_q <= '0;
            bad_q       <= 1'b0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            locked_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (vs_edge) begin
                bad_q <= 1'b0;
                if (state_q != IDLE) begin
                    if (frame_good) begin
                        h_q         <= first_len_q[10:0];
                        v_q         <= y_q;
                        have_prev_q <= 1'b1;
                        if (have_prev_q && (first_len_q[10:0] == h_q) && (y_q == v_q)) begin
                            locked_q <= 1'b1;
                        end else begin
                            locked_q <= 1'b0;
                            err_q    <= locked_q;
                        end
                    end else begin
                        locked_q    <= 1'b0;
                        err_q       <= 1'b1;
                        have_prev_q <= 1'b0;
                    end
                end
            end else begin
                if (line_done) begin
                    if (y_q == 11'd0) begin
                        first_len_q <= line_len;
                    end else if (line_len != first_len_q) begin
                        bad_q <= 1'b1;
                    end
                    if (y_q == XY_MAX) begin
                        bad_q <= 1'b1;
                    end
                end
                if (x_sat) begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    assign frame_err = err_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            v_q      <= '0;
            locked_q <= 1'b0;
        end else begin
            h_q <= 11'(H_DISP);
            v_q <= 11'(V_DISP);
            if (de_rise && (eff_state == VBLANK)) begin
                locked_q <= 1'b1;
            end
        end
    end

    assign frame_err = 1'b0;
`endif

    assign pixel_data  = data_q;
    assign pixel_valid = valid_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = fs_q;
    assign line_end    = le_q;
    assign h_active    = h_q;
    assign v_active    = v_q;
    assign rx_locked   = locked_q;
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx: scoreboard of expected pixels plus per-frame geometry checks.
`timescale 1ns/1ps
module tb_lcd_rgb_rx;
    localparam bit SYNC_POL = 1'b0;
    localparam int HD = 16;
    localparam int VD = 6;
`ifdef LCD_RX_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic        le;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lcd_hs, lcd_vs, lcd_de;
    logic [15:0] lcd_rgb;
    logic [15:0] pixel_data;
    logic        pixel_valid, frame_start, line_end, rx_locked, frame_err;
    logic [10:0] pixel_xpos, pixel_ypos, h_active, v_active;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_checks = 0, n_pass = 0;
    int   vcnt = 0, fs_cnt = 0, le_cnt = 0, err_cnt = 0;
    int   vbase = 0, fs_base = 0, le_base = 0, err_base = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    lcd_rgb_rx #(.SYNC_POL(SYNC_POL), .H_DISP(HD), .V_DISP(VD)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_rgb(lcd_rgb), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .frame_start(frame_start),
        .line_end(line_end), .h_active(h_active), .v_active(v_active),
        .rx_locked(rx_locked), .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid) begin
                vcnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pixel", {pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end}, mon_e);
                end
            end
            if (frame_start) fs_cnt++;
            if (line_end)    le_cnt++;
            if (frame_err)   err_cnt++;
        end
    end

    task automatic cyc(input bit vs_a, input bit de, input bit hs_a, input logic [15:0] rgb);
        lcd_vs  = vs_a ? SYNC_POL : ~SYNC_POL;
        lcd_hs  = hs_a ? SYNC_POL : ~SYNC_POL;
        lcd_de  = de;
        lcd_rgb = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int n, input int y, input bit first, input bit expect_px, input bit le_last);
        pix_t        e;
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            if (expect_px) begin
                e.d  = d;
                e.x  = 11'(i);
                e.y  = 11'(y);
                e.fs = first && (i == 0);
                e.le = le_last && (i == n - 1);
                exp_q.push_back(e);
                if (e.fs) started = 1'b1;
            end
            cyc(1'b0, 1'b1, 1'b0, d);
        end
    endtask

    task automatic line(input int len, input int y, input bit first, input bit expect_px);
        pixels(len, y, first, expect_px, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, i < 2, 16'h0);
    endtask

    task automatic send_lines(input int w, input int h, input int bad_y, input int bad_len);
        for (int y = 0; y < h; y++) line((y == bad_y) ? bad_len : w, y, y == 0, 1'b1);
    endtask

    task automatic vsync();
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic frame_checks(input string tag, input int exp_fs, input int exp_le,
                                input bit m_lock, input int m_h, input int m_v, input int m_err);
        chk({tag, ":fs"},   fs_cnt - fs_base, exp_fs);
        chk({tag, ":le"},   le_cnt - le_base, exp_le);
        chk({tag, ":lock"}, rx_locked, MEAS ? m_lock : started);
        chk({tag, ":h"},    h_active, MEAS ? m_h : HD);
        chk({tag, ":v"},    v_active, MEAS ? m_v : VD);
        chk({tag, ":err"},  err_cnt - err_base, MEAS ? m_err : 0);
        $display("frame %s closed: %0dx%0d locked=%0b err_pulses=%0d",
                 tag, h_active, v_active, rx_locked, err_cnt - err_base);
        fs_base  = fs_cnt;
        le_base  = le_cnt;
        err_base = err_cnt;
    endtask

    task automatic close(input string tag, input int exp_le, input bit m_lock,
                         input int m_h, input int m_v, input int m_err);
        vsync();
        frame_checks(tag, 1, exp_le, m_lock, m_h, m_v, m_err);
    endtask

    initial begin
        lcd_vs  = ~SYNC_POL;
        lcd_hs  = ~SYNC_POL;
        lcd_de  = 1'b0;
        lcd_rgb = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pix",  {pixel_data, pixel_valid, pixel_xpos, pixel_ypos, frame_start, line_end}, 0);
        chk("reset_geom", {h_active, v_active, rx_locked, frame_err}, 0);
        rst_n = 1'b1;

        // DE activity before any VS edge must be ignored.
        vbase = vcnt;
        line(HD, 0, 1'b1, 1'b0);
        line(HD, 1, 1'b0, 1'b0);
        chk("pre_vs_valid", vcnt - vbase, 0);
        vsync();
        chk("idle_h", h_active, MEAS ? 0 : HD);

        send_lines(HD, VD, -1, 0);  close("f1", VD, 1'b0, HD, VD, 0);
        send_lines(HD, VD, -1, 0);  close("f2", VD, 1'b1, HD, VD, 0);
        send_lines(HD, VD, -1, 0);  close("f3", VD, 1'b1, HD, VD, 0);

        send_lines(HD, VD, 3, HD - 1); close("short_line", VD, 1'b0, HD, VD, 1);
        send_lines(HD, VD, -1, 0);     close("clean_a",    VD, 1'b0, HD, VD, 0);
        send_lines(HD, VD, -1, 0);     close("clean_b",    VD, 1'b1, HD, VD, 0);

        send_lines(24, 4, -1, 0);   close("resize_a", 4, 1'b0, 24, 4, 1);
        send_lines(24, 4, -1, 0);   close("resize_b", 4, 1'b1, 24, 4, 0);

        // VS edge arrives while DE is still high in the middle of line 2.
        line(24, 0, 1'b1, 1'b1);
        line(24, 1, 1'b0, 1'b1);
        pixels(10, 2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        frame_checks("midline_vs", 1, 2, 1'b0, 24, 4, 1);
        send_lines(24, 4, -1, 0);   close("relock_a", 4, 1'b0, 24, 4, 0);
        send_lines(24, 4, -1, 0);   close("relock_b", 4, 1'b1, 24, 4, 0);

        // Asynchronous reset in the middle of an active line.
        line(24, 0, 1'b1, 1'b1);
        pixels(8, 1, 1'b0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        started = 1'b0;
        #1;
        chk("midrst_pix",  {pixel_data, pixel_valid, pixel_xpos, pixel_ypos, frame_start, line_end}, 0);
        chk("midrst_geom", {h_active, v_active, rx_locked, frame_err}, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        fs_base  = fs_cnt;
        le_base  = le_cnt;
        err_base = err_cnt;
        vbase    = vcnt;
        line(HD, 0, 1'b1, 1'b0);
        line(HD, 1, 1'b0, 1'b0);
        chk("post_rst_valid", vcnt - vbase, 0);
        vsync();
        send_lines(HD, VD, -1, 0);  close("post_rst", VD, 1'b0, HD, VD, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
